// File: rtl/mem_dump_ctrl.sv
// mem_dump_ctrl: releases the processing units, waits for all of them to halt
// (or for a cycle budget to expire), then reads a window of every PU data
// memory and streams the words out over a valid/ready port, PU-major.
module mem_dump_ctrl #(
  parameter int NPU            = 1,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int DUMP_WORDS     = 64,
  parameter int TIMEOUT_CYCLES = 10110
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NPU-1:0]          halt,
  output logic [NPU-1:0]          pu_run,
  output logic [NPU-1:0]          rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [NPU*DATA_W-1:0]   rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [$clog2(NPU):0]    out_pu,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    timed_out
);

  localparam int PU_W  = $clog2(NPU) + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DUMP_WORDS - 1);
  localparam logic [PU_W-1:0]   LAST_PU   = PU_W'(NPU - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_READ,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PU_W-1:0]     pu_q, pu_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                done_q, done_d;
  logic                timed_out_q, timed_out_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [PU_W-1:0]     out_pu_q, out_pu_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [NPU-1:0]      rd_en_q, rd_en_d;
  logic                run_q, out_valid_q, busy_q;
  logic [DATA_W-1:0]   sel_data;

  // Pick the read-data lane of the PU currently being dumped.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NPU; k++) begin
      if (pu_q == PU_W'(k)) sel_data = rd_data[k*DATA_W +: DATA_W];
    end
  end

  // Next-state and next-value logic for the run/dump sequence.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pu_d        = pu_q;
    addr_d      = addr_q;
    done_d      = done_q;
    timed_out_d = timed_out_q;
    out_data_d  = out_data_q;
    out_pu_d    = out_pu_q;
    out_addr_d  = out_addr_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          done_d      = 1'b0;
          timed_out_d = 1'b0;
          cnt_d       = '0;
          pu_d        = '0;
          addr_d      = '0;
        end
      end

      S_RUN: begin
        // A full halt takes priority over a budget expiring in the same cycle.
        if (&halt) begin
          state_d = S_READ;
        end else if (cnt_q == LAST_CNT) begin
          state_d     = S_READ;
          timed_out_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_READ: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        out_data_d = sel_data;
        out_pu_d   = pu_q;
        out_addr_d = addr_q;
        state_d    = S_PRESENT;
      end

      S_PRESENT: begin
        if (out_ready) begin
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            pu_d   = pu_q + PU_W'(1);
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
          if ((pu_q == LAST_PU) && (addr_q == LAST_ADDR)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // One-hot read strobe for the next cycle, decoded from the next state.
  always_comb begin
    rd_en_d = '0;
    for (int k = 0; k < NPU; k++) begin
      rd_en_d[k] = (state_d == S_READ) && (pu_d == PU_W'(k));
    end
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from the values seen before the clock edge.
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pu_q        <= '0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      out_data_q  <= '0;
      out_pu_q    <= '0;
      out_addr_q  <= '0;
      rd_en_q     <= '0;
      run_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pu_q        <= pu_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
      out_data_q  <= out_data_d;
      out_pu_q    <= out_pu_d;
      out_addr_q  <= out_addr_d;
      rd_en_q     <= rd_en_d;
      run_q       <= (state_d == S_RUN);
      out_valid_q <= (state_d == S_PRESENT);
      busy_q      <= (state_d == S_RUN) || (state_d == S_READ) ||
                     (state_d == S_WAIT) || (state_d == S_PRESENT);
    end
  end

  assign pu_run    = {NPU{run_q}};
  assign rd_en     = rd_en_q;
  assign rd_addr   = addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_pu    = out_pu_q;
  assign out_addr  = out_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timed_out = timed_out_q;

endmodule

// File: doc/mem_dump_ctrl.md
# mem_dump_ctrl

Parametrised run-and-dump controller for multi-PU simulations and on-chip self-test. It releases the processing units, waits until every PU halts or a cycle budget expires, then reads a configurable window of each PU's data memory and streams the words out over a valid/ready port. It replaces fixed-delay wait-then-print benches with a deterministic, reusable harness. It sits beside `top`, with one read port per PU data memory.

## Interface
- `NPU`, 1, number of processing units / memory channels (1..8)
- `ADDR_W`, 8, data-memory word-address width
- `DATA_W`, 32, data-memory word width
- `DUMP_WORDS`, 64, words dumped per PU, starting at address 0 (1..2**ADDR_W)
- `TIMEOUT_CYCLES`, 10110, maximum RUN-state cycles (>=1)
- `clk  in  1  clock; all state updates on posedge`
- `rst  in  1  synchronous, active-low reset (rst==0 at posedge resets)`
- `start  in  1  begin run; sampled only in IDLE or DONE`
- `halt  in  NPU  per-PU halted flag, level`
- `pu_run  out  NPU  run enable to the PUs; all bits equal`
- `rd_en  out  NPU  one-hot read strobe to the selected PU memory`
- `rd_addr  out  ADDR_W  read address, shared by all channels`
- `rd_data  in  NPU*DATA_W  read data, PU k in bits [k*DATA_W +: DATA_W], valid the cycle after rd_en`
- `out_valid  out  1  dump word available`
- `out_ready  in  1  sink accepts the word`
- `out_data  out  DATA_W  dumped word`
- `out_pu  out  $clog2(NPU)+1  source PU index`
- `out_addr  out  ADDR_W  source address`
- `busy  out  1  high in RUN, READ, WAIT, PRESENT`
- `done  out  1  sticky; dump complete`
- `timed_out  out  1  sticky; RUN ended on budget, not on halt`

## Operation
- States: IDLE, RUN, READ, WAIT, PRESENT, DONE.
- IDLE/DONE: `start`=1 -> RUN. This clears `done`, `timed_out`, the cycle counter, and the pu/addr indices.
- RUN:
  - `pu_run`=all ones; the cycle counter increments each cycle from 0.
  - Exit to READ when `&halt` is true, or when counter == TIMEOUT_CYCLES-1. On exit, `pu_run` drops.
  - Timeout exit sets `timed_out`=1. If both conditions hold in the same cycle, halt wins and `timed_out`=0.
- READ: `rd_en[pu]`=1, `rd_addr`=addr -> WAIT.
- WAIT: capture `rd_data[pu]` into `out_data`; `out_pu`/`out_addr` register the current indices -> PRESENT.
- PRESENT:
  - `out_valid`=1. `out_data`, `out_pu` and `out_addr` stay stable until `out_valid && out_ready`.
  - On accept: if addr==DUMP_WORDS-1, set addr=0 and pu++; otherwise addr++.
  - After the last word (pu==NPU-1, addr==DUMP_WORDS-1) -> DONE with `done`=1; otherwise -> READ.
- Order is PU-major, ascending address, with no gaps or repeats.
- `start` outside IDLE/DONE is ignored. `halt` outside RUN is ignored. `out_ready` outside PRESENT is ignored.
- Reset mid-operation: return to IDLE immediately, with no further `rd_en` or `out_valid`. Any partially emitted dump is discarded.

## Timing
- Reset values: `pu_run`=0, `rd_en`=0, `rd_addr`=0, `out_valid`=0, `out_data`=0, `out_pu`=0, `out_addr`=0, `busy`=0, `done`=0, `timed_out`=0.
- `start` high at posedge t gives RUN and `pu_run`=1 from cycle t+1.
- Timeout: RUN lasts exactly TIMEOUT_CYCLES cycles.
- Halt exit: `&halt` sampled at posedge t gives READ in cycle t+1.
- READ in cycle r gives WAIT in r+1 and `out_valid` in r+2.
- Minimum 3 cycles per word with `out_ready` held high. Total dump is 3*NPU*DUMP_WORDS cycles minimum.
- `done` rises the cycle after the final accept. `busy` falls in the same cycle.
- All outputs are registered; there is no combinational path from `out_ready` or `halt` to any output.

## Test plan
- NPU=1, DUMP_WORDS=4, memory preloaded with 10,-3,0,7; halt rises after 50 cycles -> words 10,-3,0,7 at addr 0..3; `timed_out`=0; `done`=1.
- NPU=2, `halt` never asserted, TIMEOUT_CYCLES=100 -> `pu_run` high for exactly 100 cycles; `timed_out`=1; 2*DUMP_WORDS words ordered pu0 then pu1.
- Random `out_ready` backpressure, with `out_ready` held low 20 cycles in PRESENT -> `out_data`/`out_addr` stable throughout; no word lost or duplicated.
- `&halt` and the timeout coincide in the same cycle -> `timed_out`=0; dump proceeds.
- `rst`=0 during PRESENT at word 2 -> next cycle all outputs at reset values. A new `start` redumps from pu0, addr0.
- `start` pulsed during RUN and PRESENT -> ignored. `start` in DONE -> clears `done`/`timed_out` and reruns.
